// File: rtl/fetch_pkg.sv
// Fetch-stage shared definitions for the gshare direction predictor.
//
// Contents:
//   LEN5_MULTIPLE_ISSUES  default number of predictions per fetch bundle
//   c2b_t                 2-bit saturating direction counter encoding
//   gshare_state_t        PHT init FSM states
//   c2b_next()            saturating counter update toward the resolved direction
package fetch_pkg;

    localparam int LEN5_MULTIPLE_ISSUES = 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } c2b_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } gshare_state_t;

    // Any encoding outside the four legal states falls back to weakly-not-taken.
    function automatic c2b_t c2b_next(input c2b_t cur, input logic taken);
        c2b_t nxt;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_spec_pred_pht_init_fsm.sv
// PHT initialisation sequencer for gshare_spec_pred.
// Walks every PHT row once (one row per cycle) after reset or flush, then
// reports ready until the next flush.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   flush_i    restart the row walk from row 0
//   init_we_o  write the init counter value this cycle
//   init_idx_o row being initialised
//   ready_o    walk complete, predictor usable
module pht_init_fsm
    import fetch_pkg::*;
#(
    parameter int PHT_IDX_W = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    output logic                 init_we_o,
    output logic [PHT_IDX_W-1:0] init_idx_o,
    output logic                 ready_o
);

    gshare_state_t        state_q, state_d;
    logic [PHT_IDX_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flush restarts the walk from any state; the last row hands over to READY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = INIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                INIT: begin
                    cnt_d = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_d = READY;
                    end
                end
                READY:   state_d = READY;
                default: state_d = INIT;
            endcase
        end
    end

    always_comb begin
        init_we_o  = (state_q == INIT);
        init_idx_o = cnt_q;
        ready_o    = (state_q == READY);
    end

endmodule

// File: rtl/gshare_spec_pred.sv
// Multi-lane gshare direction predictor with speculative global history.
// Each prediction returns the history snapshot it used; a mispredicted
// resolution restores the history from that snapshot plus the real outcome.
//
// Optional feature macro: GSHARE_UPDATE_BYPASS_EN
//   defined   -> a resolution writing the row being read this cycle forwards
//                the updated counter to taken_o
//   undefined -> taken_o sees the stored counter; the update shows next cycle
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                clear history, restart PHT initialisation
//   pred_valid_i           prediction request (accepted when pred_ready_o)
//   pred_ready_o           PHT initialised
//   pred_pc_i              bundle base PC, lane l at base + 4*l
//   pred_lanes_i           valid-lane mask
//   taken_o                per-lane predicted direction
//   pred_hist_o            history snapshot used by this prediction
//   res_valid_i            branch resolution
//   res_pc_i, res_hist_i   resolved branch PC and its history snapshot
//   res_taken_i            actual direction
//   res_mispred_i          direction mispredicted, restore history
module gshare_spec_pred
    import fetch_pkg::*;
#(
    parameter int   HLEN      = 8,
    parameter int   PHT_IDX_W = 10,
    parameter int   NLANES    = LEN5_MULTIPLE_ISSUES,
    parameter int   XLEN      = 32,
    parameter c2b_t INIT_C2B  = WNT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              pred_valid_i,
    output logic              pred_ready_o,
    input  logic [XLEN-1:0]   pred_pc_i,
    input  logic [NLANES-1:0] pred_lanes_i,
    output logic [NLANES-1:0] taken_o,
    output logic [HLEN-1:0]   pred_hist_o,
    input  logic              res_valid_i,
    input  logic [XLEN-1:0]   res_pc_i,
    input  logic [HLEN-1:0]   res_hist_i,
    input  logic              res_taken_i,
    input  logic              res_mispred_i
);

    localparam int PhtRows = 2 ** PHT_IDX_W;

    c2b_t                 pht_q [PhtRows];
    logic [HLEN-1:0]      ghr_q, ghr_d;

    logic                 init_we;
    logic [PHT_IDX_W-1:0] init_idx;
    logic                 ready;

    logic [PHT_IDX_W-1:0] rd_idx [NLANES];
    logic [PHT_IDX_W-1:0] res_idx;
    logic                 res_we;
    c2b_t                 pht_d;

    logic                 pht_we;
    logic [PHT_IDX_W-1:0] pht_widx;
    c2b_t                 pht_wdata;
    logic                 accept;

    // PC bits outside the index field do not take part in the hash.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc_i[XLEN-1:PHT_IDX_W+2], pred_pc_i[1:0],
                              res_pc_i[XLEN-1:PHT_IDX_W+2], res_pc_i[1:0]};

    pht_init_fsm #(
        .PHT_IDX_W (PHT_IDX_W)
    ) u_init_fsm (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .init_we_o  (init_we),
        .init_idx_o (init_idx),
        .ready_o    (ready)
    );

    assign pred_ready_o = ready;
    assign pred_hist_o  = ghr_q;
    assign accept       = pred_valid_i & ready;

    // Resolution update: flush and the init walk both suppress it.
    always_comb begin
        res_idx = res_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(res_hist_i);
        res_we  = res_valid_i & ready & ~flush_i;
        pht_d   = c2b_next(pht_q[res_idx], res_taken_i);
    end

    // Single write port; the init walk has priority over resolutions.
    always_comb begin
        pht_we    = 1'b0;
        pht_widx  = '0;
        pht_wdata = INIT_C2B;
        if (init_we) begin
            pht_we    = 1'b1;
            pht_widx  = init_idx;
            pht_wdata = INIT_C2B;
        end else if (res_we) begin
            pht_we    = 1'b1;
            pht_widx  = res_idx;
            pht_wdata = pht_d;
        end
    end

    // Counter storage is not reset; the init walk defines its contents.
    always_ff @(posedge clk_i) begin
        if (pht_we) begin
            pht_q[pht_widx] <= pht_wdata;
        end
    end

    // Lane l reads the sequential PC row (wrapping) hashed with the history.
    always_comb begin
        for (int l = 0; l < NLANES; l++) begin
            rd_idx[l] = (pred_pc_i[PHT_IDX_W+1:2] + PHT_IDX_W'(l)) ^ PHT_IDX_W'(ghr_q);
            taken_o[l] = 1'b0;
            if (ready) begin
`ifdef GSHARE_UPDATE_BYPASS_EN
                if (res_we && (res_idx == rd_idx[l])) begin
                    taken_o[l] = pht_d[1] & pred_lanes_i[l];
                end else begin
                    taken_o[l] = pht_q[rd_idx[l]][1] & pred_lanes_i[l];
                end
`else
                taken_o[l] = pht_q[rd_idx[l]][1] & pred_lanes_i[l];
`endif
            end
        end
    end

    // History priority: flush, then mispredict restore, then speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (flush_i) begin
            ghr_d = '0;
        end else if (ready && res_valid_i && res_mispred_i) begin
            ghr_d = {res_hist_i[HLEN-2:0], res_taken_i};
        end else if (accept) begin
            ghr_d = {ghr_q[HLEN-2:0], |taken_o};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

endmodule
